// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the mult/div sequencer: FSM state encoding,
// operation type, counter width and default watchdog limit.
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  localparam int unsigned CNT_W              = 6;
  localparam int unsigned MAX_CYCLES_DEFAULT = 40;

endpackage

// File: rtl/multdiv_sequencer.sv
// Sequences one mul/div through an iterative unit, stalling the pipeline and
// registering the writeback. Optional macro: MULTDIV_DIV0_CHECK_EN (divide-by-zero bypass).
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic        ctrl_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        unit_start_mult,
  output logic        unit_start_div,
  output logic [31:0] unit_op_a,
  output logic [31:0] unit_op_b,
  input  logic [31:0] unit_result,
  input  logic        unit_exception,
  input  logic        unit_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_exception
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  state_e           state;
  op_e              op_q;
  logic             first_q;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic             req;
  logic             div0_skip;

  assign req = ctrl_mult | ctrl_div;

`ifdef MULTDIV_DIV0_CHECK_EN
  assign div0_skip = !ctrl_mult && ctrl_div && (op_b == '0);
`else
  assign div0_skip = 1'b0;
`endif

  // Start pulses are decoded from the registered first-RUN-cycle flag and op type.
  assign unit_start_mult = first_q && (op_q == OP_MUL);
  assign unit_start_div  = first_q && (op_q == OP_DIV);

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      stall = ((state == ST_IDLE) && req && !flush) || (state == ST_RUN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= OP_MUL;
      first_q      <= 1'b0;
      cnt          <= '0;
      rd_q         <= '0;
      unit_op_a    <= '0;
      unit_op_b    <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_exception <= 1'b0;
    end else begin
      first_q  <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && !flush) begin
            unit_op_a <= op_a;
            unit_op_b <= op_b;
            rd_q      <= rd_in;
            op_q      <= ctrl_mult ? OP_MUL : OP_DIV;
            cnt       <= '0;
            if (div0_skip) begin
              state        <= ST_DONE;
              wb_valid     <= 1'b1;
              wb_data      <= '0;
              wb_exception <= 1'b1;
              wb_rd        <= rd_in;
            end else begin
              state   <= ST_RUN;
              first_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (flush) begin
            state <= ST_IDLE;
          end else if (unit_ready) begin
            state        <= ST_DONE;
            wb_valid     <= 1'b1;
            wb_data      <= unit_result;
            wb_exception <= unit_exception;
            wb_rd        <= rd_q;
          end else if (cnt == WD_LAST) begin
            state        <= ST_DONE;
            wb_valid     <= 1'b1;
            wb_data      <= '0;
            wb_exception <= 1'b1;
            wb_rd        <= rd_q;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed and randomized bench for multdiv_sequencer against a transaction-level model.
module tb_multdiv_sequencer;

  localparam int MAXC = 40;
`ifdef MULTDIV_DIV0_CHECK_EN
  localparam bit DIV0_EN = 1'b1;
`else
  localparam bit DIV0_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_mult, ctrl_div, flush;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        unit_start_mult, unit_start_div;
  logic [31:0] unit_op_a, unit_op_b;
  logic [31:0] unit_result;
  logic        unit_exception, unit_ready;
  logic        stall, wb_valid, wb_exception;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cnt = 0;

  multdiv_sequencer #(.MAX_CYCLES(MAXC)) dut (
    .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
    .unit_start_mult(unit_start_mult), .unit_start_div(unit_start_div),
    .unit_op_a(unit_op_a), .unit_op_b(unit_op_b), .unit_result(unit_result),
    .unit_exception(unit_exception), .unit_ready(unit_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (stall === 1'b1) stall_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One operation: the model derives the outcome from latency, flush point and watchdog.
  task automatic run_op(input bit is_mul, input bit both, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int lat,
                        input logic [31:0] res, input bit exc, input int fl);
    int run_cycles;
    int stall0;
    bit flushed, skip;
    logic [31:0] exp_data;
    bit exp_exc;
    skip = DIV0_EN && !is_mul && (b == 0);
    flushed = (fl <= lat) && (fl <= MAXC - 1);
    if (lat <= MAXC - 1) begin exp_data = res; exp_exc = exc; end
    else begin exp_data = 0; exp_exc = 1'b1; end
    run_cycles = skip ? 0 : ((fl < lat ? fl : lat) < MAXC - 1 ? (fl < lat ? fl : lat) + 1 : MAXC);
    if (skip) begin exp_data = 0; exp_exc = 1'b1; flushed = 1'b0; end

    stall0 = stall_cnt;
    ctrl_mult = is_mul; ctrl_div = !is_mul || both;
    op_a = a; op_b = b; rd_in = rd; flush = 1'b0; unit_ready = 1'b0;
    #1;
    check("accept_stall", stall, 1);
    tick();
    if (!skip) begin
      for (int i = 0; i < 64; i++) begin
        op_a = $urandom; op_b = $urandom;
        unit_ready = (i == lat); unit_result = res; unit_exception = exc;
        flush = (i == fl);
        #1;
        check("run_stall", stall, 1);
        check("start_mult", unit_start_mult, (is_mul && i == 0));
        check("start_div", unit_start_div, (!is_mul && i == 0));
        check("unit_op_a", unit_op_a, a);
        check("unit_op_b", unit_op_b, b);
        check("run_wb_valid", wb_valid, 0);
        tick();
        if (i == fl || i == lat || i == MAXC - 1) break;
      end
    end
    unit_ready = 1'b0; flush = 1'b0;
    if (flushed) begin
      ctrl_mult = 1'b0; ctrl_div = 1'b0;
      #1;
      check("flush_wb_valid", wb_valid, 0);
      check("flush_stall", stall, 0);
    end else begin
      #1;
      check("done_wb_valid", wb_valid, 1);
      check("done_wb_data", wb_data, exp_data);
      check("done_wb_rd", wb_rd, rd);
      check("done_wb_exc", wb_exception, exp_exc);
      check("done_stall", stall, 0);
      check("done_no_start", {unit_start_mult, unit_start_div}, 0);
      tick();
      ctrl_mult = 1'b0; ctrl_div = 1'b0;
      #1;
      check("post_wb_valid", wb_valid, 0);
      check("hold_wb_data", wb_data, exp_data);
      check("hold_wb_rd", wb_rd, rd);
    end
    check("stall_cycles", stall_cnt - stall0, run_cycles + 1);
    tick();
  endtask

  initial begin
    reset = 1'b1; ctrl_mult = 0; ctrl_div = 0; flush = 0;
    op_a = 0; op_b = 0; rd_in = 0; unit_result = 0; unit_exception = 0; unit_ready = 0;
    tick(); tick();
    check("rst_stall", stall, 0);
    check("rst_outs", {unit_start_mult, unit_start_div, wb_valid, wb_exception}, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_unit_op", unit_op_a | unit_op_b, 0);
    reset = 1'b0;
    tick();

    // mul 7*6 -> 42 with 34 stall cycles in total
    run_op(1, 0, 7, 6, 3, 32, 42, 0, 99);
    // div 100/7
    run_op(0, 0, 100, 7, 9, 10, 14, 0, 99);
    // both requests: mul wins
    run_op(1, 1, 5, 5, 4, 2, 25, 0, 99);
    // ready on first RUN cycle
    run_op(0, 0, 8, 2, 1, 0, 4, 1, 99);
    // watchdog
    run_op(1, 0, 1, 2, 17, 99, 32'hdead, 0, 99);
    // ready one cycle too late for the watchdog, and exactly in time
    run_op(1, 0, 3, 3, 18, MAXC, 9, 0, 99);
    run_op(1, 0, 3, 3, 19, MAXC - 1, 9, 0, 99);
    // flush with simultaneous ready
    run_op(0, 0, 50, 5, 6, 7, 10, 0, 7);
    // flush with simultaneous watchdog expiry
    run_op(1, 0, 2, 2, 7, 99, 4, 0, MAXC - 1);
    // divide by zero
    run_op(0, 0, 77, 0, 12, 5, 32'h1234, 1, 99);

    // request with flush in IDLE is not accepted
    ctrl_mult = 1; flush = 1; op_a = 11; op_b = 12; rd_in = 2;
    #1;
    check("idle_flush_stall", stall, 0);
    tick();
    ctrl_mult = 0; flush = 0;
    #1;
    check("idle_flush_no_start", {unit_start_mult, unit_start_div}, 0);
    check("idle_flush_stall2", stall, 0);
    tick();

    // reset on the fifth RUN cycle
    ctrl_mult = 1; op_a = 9; op_b = 9; rd_in = 5;
    tick();
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    check("rst_run_stall", stall, 0);
    tick();
    reset = 1'b0; ctrl_mult = 0;
    #1;
    check("midrst_outs", {unit_start_mult, unit_start_div, wb_valid, wb_exception, stall}, 0);
    check("midrst_unit_op", unit_op_a | unit_op_b, 0);
    check("midrst_wb", {27'd0, wb_rd} | wb_data, 0);
    tick();
    #1;
    check("postrst_no_start", {unit_start_mult, unit_start_div}, 0);
    tick();
    run_op(1, 0, 12, 12, 30, 3, 144, 0, 99);

    // randomized operations
    for (int k = 0; k < 14; k++) begin
      bit m;
      logic [31:0] ra, rb;
      int lat, fl;
      m = $urandom_range(0, 1);
      ra = $urandom; rb = $urandom | 32'd1;
      lat = $urandom_range(0, MAXC + 3);
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXC) : 99;
      run_op(m, 0, ra, rb, 5'($urandom), lat, $urandom, 1'($urandom), fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
